// File: rtl/keystream_framer_pkg.sv
// Shared types and constants for the keystream framer: the FSM state encoding,
// the sync header word, and the helpers for the 32-bit reseed LFSR.
package keystream_framer_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int FRAC_BITS_DEF  = 30;
   localparam int SAMPLE_W_DEF   = 16;

   localparam logic [31:0] SYNC_WORD = 32'h5A5A_C3C3;

   // Galois mask for x^32 + x^22 + x^2 + x + 1, right-shifting form
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      DATA       = 2'd0,
      RESEED     = 2'd1,
      SYNC_HDR   = 2'd2,
      SYNC_STATE = 2'd3
   } state_t;

   // One step of the right-shifting Galois LFSR
   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

   // Reseed value is a Q2.30 number in [0,1); an all-zero fraction would be a
   // fixed point of the map, so it is replaced by the smallest nonzero value
   function automatic logic [31:0] reseed_value(input logic [31:0] cur);
      reseed_value = (cur[29:0] == 30'd0) ? 32'h0000_0001 : {2'b00, cur[29:0]};
   endfunction

endpackage

// File: rtl/keystream_framer_if.sv
// Sample-in / beat-out handshake bundle of the keystream framer.
// master: the framer itself (consumes samples, produces beats).
// slave:  the surrounding audio source and link serialiser.
interface keystream_framer_if #(
   parameter int SAMPLE_W   = 16,
   parameter int DATA_WIDTH = 32
) ();

   logic                  s_valid;
   logic                  s_ready;
   logic [SAMPLE_W-1:0]   s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_is_sync;

   modport master (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_is_sync
   );

   modport slave (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_is_sync
   );

endinterface

// File: rtl/keystream_framer_reseed_lfsr.sv
// 32-bit Galois LFSR that supplies fresh seeds for the chaotic generator
// whenever the keystream collapses. Advances only when step is high.
module keystream_framer_reseed_lfsr
   import keystream_framer_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [31:0] state
);

   // Hold the seed in reset, advance one step per enabled cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else if (step) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/keystream_framer.sv
// TX-side keystream framer: XORs PCM samples with 16 key bits from the chaotic
// generator, inserts a header + generator-state sync frame every SYNC_PERIOD
// samples, and reseeds the generator from an LFSR when the key degenerates.
module keystream_framer
   import keystream_framer_pkg::*;
#(
   parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int          FRAC_BITS   = FRAC_BITS_DEF,
   parameter int          SAMPLE_W    = SAMPLE_W_DEF,
   parameter int          SYNC_PERIOD = 256,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  rst,
   keystream_framer_if.master    bus,
   input  logic [DATA_WIDTH-1:0] key_in,
   output logic                  next_key_en,
   output logic                  sync_en,
   output logic [DATA_WIDTH-1:0] sync_state_out
);

   localparam int CNT_W = $clog2(SYNC_PERIOD + 1);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      sample_cnt;
   logic [DATA_WIDTH-1:0] last_key;
   logic                  last_key_vld;
   logic [31:0]           lfsr;

   logic                  free;
   logic                  degen;
   logic                  accept;
   logic                  period_done;
   logic                  load;
   logic                  load_sync;
   logic [DATA_WIDTH-1:0] load_data;
   logic [SAMPLE_W-1:0]   cipher;

   // The output slot can take a new beat when empty or being drained this cycle
   assign free        = !bus.m_valid || bus.m_ready;
   // Zero or a repeated key means the fixed-point map has collapsed
   assign degen       = (key_in == '0) || (last_key_vld && (key_in == last_key));
   // This accept is the last sample of the current sync period
   assign period_done = (sample_cnt == CNT_W'(SYNC_PERIOD - 1));
   assign cipher      = bus.s_data ^ key_in[FRAC_BITS-1 -: SAMPLE_W];

   keystream_framer_reseed_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (state == RESEED),
      .state (lfsr)
   );

   // FSM state register; every stream opens with a sync frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SYNC_HDR;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         DATA: begin
            if (degen) begin
               state_nxt = RESEED;
            end else if (accept && period_done) begin
               state_nxt = SYNC_HDR;
            end
         end
         RESEED:     state_nxt = SYNC_HDR;
         SYNC_HDR:   if (free) state_nxt = SYNC_STATE;
         SYNC_STATE: if (free) state_nxt = DATA;
         default:    state_nxt = SYNC_HDR;
      endcase
   end

   // FSM outputs: handshake, generator control and the beat to load
   always_comb begin
      bus.s_ready    = 1'b0;
      accept         = 1'b0;
      next_key_en    = 1'b0;
      sync_en        = 1'b0;
      sync_state_out = '0;
      load           = 1'b0;
      load_sync      = 1'b0;
      load_data      = '0;
      case (state)
         DATA: begin
            bus.s_ready = free && !degen;
            accept      = bus.s_valid && free && !degen;
            next_key_en = accept;
            load        = accept;
            load_data   = DATA_WIDTH'(cipher);
         end
         RESEED: begin
            sync_en        = 1'b1;
            sync_state_out = DATA_WIDTH'(reseed_value(lfsr));
         end
         SYNC_HDR: begin
            load      = free;
            load_sync = 1'b1;
            load_data = DATA_WIDTH'(SYNC_WORD);
         end
         SYNC_STATE: begin
            // Unconsumed state: the next data sample reuses this same key,
            // exactly as the RX generator will after loading it
            load      = free;
            load_sync = 1'b1;
            load_data = key_in;
         end
         default: ;
      endcase
   end

   // Single-entry output slot; contents frozen while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_valid   <= 1'b0;
         bus.m_data    <= '0;
         bus.m_is_sync <= 1'b0;
      end else if (load) begin
         bus.m_valid   <= 1'b1;
         bus.m_data    <= load_data;
         bus.m_is_sync <= load_sync;
      end else if (bus.m_ready) begin
         bus.m_valid   <= 1'b0;
      end
   end

   // Sample counting and last-consumed-key tracking for degeneracy detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt   <= '0;
         last_key     <= '0;
         last_key_vld <= 1'b0;
      end else if (state == RESEED) begin
         sample_cnt   <= '0;
         last_key_vld <= 1'b0;
      end else if (accept) begin
         last_key     <= key_in;
         last_key_vld <= 1'b1;
         sample_cnt   <= period_done ? '0 : sample_cnt + CNT_W'(1);
      end
   end

endmodule
